// File: rtl/ysyx_25040129_imem_rsp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ysyx_25040129_imem_rsp
// Description : AXI4-Lite read-channel responder modelling the instruction
//               memory behind the IFU fetch port. Accepts one AR request at
//               a time, waits a programmable (optionally LFSR-randomised)
//               latency, and returns one R beat from an internal word array.
//               A side-band preload port fills the array at any time.
// Ports       : clk, rst                 clock / async active-high reset
//               araddr, arvalid, arready AR channel (byte address)
//               rdata, rresp, rvalid,    R channel (OKAY=2'b00, SLVERR=2'b10)
//               rready
//               ld_we, ld_addr, ld_data  preload write port (word index)
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040129_imem_rsp #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          DEPTH        = 4096,
  parameter int          READ_LATENCY = 1,
  parameter int          RAND_DELAY   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  input  logic                     ld_we,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);

  localparam int          c_aw     = $clog2(DEPTH);
  localparam logic [31:0] c_span   = 32'(DEPTH * 4);
  // Zero total latency: response is produced combinationally from araddr.
  localparam bit          c_comb   = (READ_LATENCY == 0) && (RAND_DELAY == 0);
  localparam logic [1:0]  c_okay   = 2'b00;
  localparam logic [1:0]  c_slverr = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  r_lfsr;
  logic [31:0] r_addr;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] r_mem [DEPTH];

  logic        w_cap_a;   // capture decode of live araddr into R registers
  logic        w_cap_q;   // capture decode of latched address into R registers
  logic        w_load;    // latch address and load the wait counter
  logic [7:0]  w_delay;
  logic        w_lfsr_fb;

  // Decode of the live request address.
  logic [31:0] w_a_off;
  logic        w_a_err;
  logic [31:0] w_a_data;
  logic [1:0]  w_a_resp;

  // Decode of the address latched at the handshake.
  logic [31:0] w_q_off;
  logic        w_q_err;
  logic [31:0] w_q_data;
  logic [1:0]  w_q_resp;

  // Offset uses 32-bit wrap, so addresses below the base land far out of range.
  assign w_a_off  = araddr - BASE_ADDR;
  assign w_a_err  = (araddr[1:0] != 2'b00) || (w_a_off >= c_span);
  assign w_a_data = w_a_err ? 32'd0 : r_mem[w_a_off[c_aw+1:2]];
  assign w_a_resp = w_a_err ? c_slverr : c_okay;

  assign w_q_off  = r_addr - BASE_ADDR;
  assign w_q_err  = (r_addr[1:0] != 2'b00) || (w_q_off >= c_span);
  assign w_q_data = w_q_err ? 32'd0 : r_mem[w_q_off[c_aw+1:2]];
  assign w_q_resp = w_q_err ? c_slverr : c_okay;

  // Total delay for a request accepted this cycle.
  assign w_delay   = 8'(READ_LATENCY) + ((RAND_DELAY != 0) ? {6'd0, r_lfsr[1:0]} : 8'd0);
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_comb begin
    w_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rdata       = r_rdata;
    rresp       = r_rresp;
    w_cap_a     = 1'b0;
    w_cap_q     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        arready = 1'b1;
        if (c_comb) begin
          if (arvalid) begin
            rvalid = 1'b1;
            rdata  = w_a_data;
            rresp  = w_a_resp;
            // Unconsumed response must be held stable, so park it in RESP.
            if (!rready) begin
              w_cap_a     = 1'b1;
              w_state_nxt = ST_RESP;
            end
          end
        end else if (arvalid) begin
          if (w_delay <= 8'd1) begin
            w_cap_a     = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Counter reaching zero on this edge ends the wait.
        if (r_cnt <= 8'd1) begin
          w_cap_q     = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_lfsr  <= 8'hA5;
      r_addr  <= 32'd0;
      r_rdata <= 32'd0;
      r_rresp <= c_okay;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= {r_lfsr[6:0], w_lfsr_fb};
      if (w_load) begin
        r_cnt  <= w_delay - 8'd1;
        r_addr <= araddr;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_cap_a) begin
        r_rdata <= w_a_data;
        r_rresp <= w_a_resp;
      end else if (w_cap_q) begin
        r_rdata <= w_q_data;
        r_rresp <= w_q_resp;
      end
    end
  end

  // Array is not reset; reads in the same cycle observe the old word.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040129_imem_rsp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ysyx_25040129_imem_rsp
// Description : Self-checking bench for ysyx_25040129_imem_rsp. Four
//               instances share clock, reset and preload port:
//                 0: latency 1   1: latency 0   2: latency 3 + random
//                 3: latency 5
//               A word-array model in the bench predicts every response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040129_imem_rsp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr [4];
  logic [3:0]  arvalid;
  logic [3:0]  arready;
  logic [31:0] rdata [4];
  logic [1:0]  rresp [4];
  logic [3:0]  rvalid;
  logic [3:0]  rready;
  logic        ld_we;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_mem [4096];

  always #5 clk = ~clk;

  ysyx_25040129_imem_rsp #(.READ_LATENCY(1), .RAND_DELAY(0)) u_n1 (
    .clk(clk), .rst(rst), .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
  ysyx_25040129_imem_rsp #(.READ_LATENCY(0), .RAND_DELAY(0)) u_n0 (
    .clk(clk), .rst(rst), .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
  ysyx_25040129_imem_rsp #(.READ_LATENCY(3), .RAND_DELAY(1)) u_r3 (
    .clk(clk), .rst(rst), .araddr(araddr[2]), .arvalid(arvalid[2]), .arready(arready[2]),
    .rdata(rdata[2]), .rresp(rresp[2]), .rvalid(rvalid[2]), .rready(rready[2]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));
  ysyx_25040129_imem_rsp #(.READ_LATENCY(5), .RAND_DELAY(0)) u_n5 (
    .clk(clk), .rst(rst), .araddr(araddr[3]), .arvalid(arvalid[3]), .arready(arready[3]),
    .rdata(rdata[3]), .rresp(rresp[3]), .rvalid(rvalid[3]), .rready(rready[3]),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode: byte offset from base, word aligned and inside 16 KiB.
  function automatic logic [33:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h8000_0000;
    if ((a % 4) != 0 || off >= 32'd16384) return {2'b10, 32'd0};
    return {2'b00, model_mem[off >> 2]};
  endfunction

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  // One read transaction on instance k. rready stays low for 'hold' cycles
  // after rvalid first appears. Optional preload write in the AR cycle.
  task automatic do_read(input int k, input logic [31:0] addr, input int hold,
                         input logic [31:0] exp_d, input logic [1:0] exp_r,
                         input bit do_ld, input logic [11:0] la, input logic [31:0] lv,
                         output int dly);
    int cyc;
    @(posedge clk); #1;
    araddr[k]  = addr;
    arvalid[k] = 1'b1;
    rready[k]  = (hold == 0);
    if (do_ld) begin
      ld_we = 1'b1; ld_addr = la; ld_data = lv;
    end
    @(negedge clk);
    chk($sformatf("arready_idle%0d", k), {31'd0, arready[k]}, 32'd1);
    if (rvalid[k]) begin
      dly = 0;
    end else begin
      @(posedge clk); #1;
      arvalid[k] = 1'b0;
      ld_we      = 1'b0;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (!rvalid[k]) chk($sformatf("arready_wait%0d", k), {31'd0, arready[k]}, 32'd0);
      end while (!rvalid[k] && cyc < 16);
      if (!rvalid[k]) chk($sformatf("rvalid_timeout%0d", k), {31'd0, rvalid[k]}, 32'd1);
      dly = cyc;
    end
    chk($sformatf("rdata%0d", k), rdata[k], exp_d);
    chk($sformatf("rresp%0d", k), {30'd0, rresp[k]}, {30'd0, exp_r});
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      arvalid[k] = 1'b0;
      ld_we      = 1'b0;
      @(negedge clk);
      chk($sformatf("hold_rvalid%0d", k), {31'd0, rvalid[k]}, 32'd1);
      chk($sformatf("hold_rdata%0d", k), rdata[k], exp_d);
      chk($sformatf("hold_rresp%0d", k), {30'd0, rresp[k]}, {30'd0, exp_r});
      chk($sformatf("hold_arready%0d", k), {31'd0, arready[k]}, 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      rready[k] = 1'b1;
      @(negedge clk);
      chk($sformatf("final_rvalid%0d", k), {31'd0, rvalid[k]}, 32'd1);
      chk($sformatf("final_rdata%0d", k), rdata[k], exp_d);
    end
    @(posedge clk); #1;
    arvalid[k] = 1'b0;
    rready[k]  = 1'b0;
    ld_we      = 1'b0;
  endtask

  // Convenience wrapper: expected response from the model, no preload.
  task automatic read_model(input int k, input logic [31:0] addr, input int hold, output int dly);
    logic [33:0] e;
    e = model_read(addr);
    do_read(k, addr, hold, e[31:0], e[33:32], 1'b0, 12'd0, 32'd0, dly);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          dly;
    logic [31:0] old7;
    logic [31:0] addr;
    logic [3:0]  seen;
    int          r;
    int          w;

    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    arvalid = '0; rready = '0;
    for (int i = 0; i < 4; i++) araddr[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_arready%0d", i), {31'd0, arready[i]}, 32'd1);
      chk($sformatf("rst_rvalid%0d", i), {31'd0, rvalid[i]}, 32'd0);
      chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
      chk($sformatf("rst_rresp%0d", i), {30'd0, rresp[i]}, 32'd0);
    end

    @(posedge clk); #1;
    for (int i = 2; i < 64; i++) preload(12'(i), $urandom);
    preload(12'd0, 32'h0000_0013);
    preload(12'd1, 32'h0010_0093);
    preload(12'd7, 32'h0000_0777);
    preload(12'd4095, 32'hCAFE_F00D);

    // Latency 1 reads.
    read_model(0, 32'h8000_0000, 0, dly);
    chk("n1_dly0", 32'(dly), 32'd1);
    read_model(0, 32'h8000_0004, 0, dly);
    chk("n1_dly1", 32'(dly), 32'd1);
    do_read(0, 32'h8000_0004, 0, 32'h0010_0093, 2'b00, 1'b0, 12'd0, 32'd0, dly);

    // Error and boundary decodes.
    do_read(0, 32'h8000_0002, 0, 32'd0, 2'b10, 1'b0, 12'd0, 32'd0, dly);
    do_read(0, 32'h8000_4000, 1, 32'd0, 2'b10, 1'b0, 12'd0, 32'd0, dly);
    do_read(0, 32'h7FFF_FFFC, 0, 32'd0, 2'b10, 1'b0, 12'd0, 32'd0, dly);
    do_read(0, 32'h8000_3FFC, 0, 32'hCAFE_F00D, 2'b00, 1'b0, 12'd0, 32'd0, dly);

    // Zero-latency path: same-cycle response, then a held response.
    do_read(1, 32'h8000_0004, 0, 32'h0010_0093, 2'b00, 1'b0, 12'd0, 32'd0, dly);
    chk("n0_dly", 32'(dly), 32'd0);
    do_read(1, 32'h8000_0004, 3, 32'h0010_0093, 2'b00, 1'b0, 12'd0, 32'd0, dly);
    chk("n0_hold_dly", 32'(dly), 32'd0);
    do_read(1, 32'h8000_4000, 0, 32'd0, 2'b10, 1'b0, 12'd0, 32'd0, dly);

    // Preload write coincident with a zero-latency read: old value returned.
    old7 = model_mem[7];
    do_read(1, 32'h8000_001C, 0, old7, 2'b00, 1'b1, 12'd7, 32'hDEAD_BEEF, dly);
    model_mem[7] = 32'hDEAD_BEEF;
    read_model(1, 32'h8000_001C, 0, dly);
    do_read(1, 32'h8000_001C, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 12'd0, 32'd0, dly);

    // Latency 5 read, then reset asserted two cycles into the wait.
    read_model(3, 32'h8000_0000, 0, dly);
    chk("n5_dly", 32'(dly), 32'd5);
    @(posedge clk); #1;
    araddr[3] = 32'h8000_0004; arvalid[3] = 1'b1; rready[3] = 1'b1;
    @(negedge clk);
    chk("n5_rst_arready_pre", {31'd0, arready[3]}, 32'd1);
    @(posedge clk); #1;
    arvalid[3] = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("n5_rst_rvalid", {31'd0, rvalid[3]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("n5_rel_arready", {31'd0, arready[3]}, 32'd1);
    repeat (7) @(negedge clk);
    chk("n5_dropped_rvalid", {31'd0, rvalid[3]}, 32'd0);
    read_model(3, 32'h8000_0004, 0, dly);
    chk("n5_after_rst_dly", 32'(dly), 32'd5);

    // Randomised latency with mixed addresses and back-pressure.
    seen = 4'd0;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        w = $urandom_range(0, 64);
        if (w == 64) w = 4095;
        addr = 32'h8000_0000 + 32'(w) * 4;
      end else if (r == 8) begin
        addr = 32'h8000_0000 + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
      end else begin
        addr = 32'h8000_4000 + 32'($urandom_range(0, 1023)) * 4;
      end
      read_model(2, addr, $urandom_range(0, 2), dly);
      chk("rand_dly_range", {31'd0, (dly >= 3 && dly <= 6)}, 32'd1);
      if (dly >= 3 && dly <= 6) seen[dly-3] = 1'b1;
    end
    chk("rand_dly_all_seen", {28'd0, seen}, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_25040129_imem_rsp.md
# ysyx_25040129_imem_rsp

AXI4-Lite read-channel responder that models the instruction memory seen by the fetch unit: accepts one AR request at a time, waits a programmable (optionally randomised) latency, then returns one R beat from an internal word array. It sits on the far end of the IFU fetch port in simulation and FPGA bring-up builds. It also has a side-band preload port for filling the array before or during a run.

## Interface
- BASE_ADDR, 32'h8000_0000, byte address mapped to word 0 of the array
- DEPTH, 4096, number of 32-bit words (power of two)
- READ_LATENCY, 1, cycles from AR handshake to rvalid (0 allowed)
- RAND_DELAY, 0, 1 adds lfsr[1:0] extra cycles per request

- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- araddr  in  32  read byte address
- arvalid  in  1  request valid
- arready  out  1  request accepted when arvalid&arready
- rdata  out  32  read data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rvalid  out  1  response valid
- rready  in  1  response consumed when rvalid&rready
- ld_we  in  1  preload write enable
- ld_addr  in  $clog2(DEPTH)  preload word index
- ld_data  in  32  preload word

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: arready=1. On arvalid:
  - READ_LATENCY=0 and RAND_DELAY=0: rvalid=arvalid combinationally, rdata/rresp decoded from araddr the same cycle; if rready also high, transfer completes, stay IDLE; if rready low, latch rdata/rresp into registers, go RESP.
  - Otherwise: latch araddr, load counter = READ_LATENCY + (RAND_DELAY ? lfsr[1:0] : 0) - 1; go WAIT (or RESP directly if total delay is 1).
- WAIT: arready=0, rvalid=0; counter decrements each cycle; at 0 capture array word and rresp into registers, go RESP.
- RESP: arready=0, rvalid=1, rdata/rresp stable; on rready go IDLE. No back-to-back accept in the handshake cycle (next AR no earlier than following cycle).
- Decode: off = addr - BASE_ADDR (32-bit wrap). SLVERR if addr[1:0]!=0 or off >= DEPTH*4; then rdata=0. Otherwise rdata = mem[off[...:2]], OKAY.
- Preload: ld_we writes mem[ld_addr] on posedge, any state. Read of same word in same cycle returns old value (read-before-write).
- LFSR: 8-bit, taps x^8+x^6+x^5+x^4+1, seeds 8'hA5 on rst, advances every cycle.
- Counter 8 bits; READ_LATENCY+3 must fit.

## Timing
- Reset (async, any state, mid-transaction included): state IDLE, arready=1 after deassert, rvalid=0, rdata=0, rresp=2'b00, counter=0, lfsr=8'hA5; pending request dropped. Memory contents not reset.
- Handshake at edge t, latency N>=1 (no random): rvalid high from cycle t+N until rready sampled high.
- RAND_DELAY=1: total delay N+lfsr[1:0], lfsr sampled at the AR handshake edge; range N..N+3.
- rdata/rresp must not change while rvalid=1 and rready=0.
- Throughput with N=1 and rready held high: one request per 2 cycles; N=0 combinational path: one per cycle.

## Test plan
- Preload mem[0]=32'h0000_0013, mem[1]=32'h0010_0093; N=1, rready=1; read 0x8000_0000 then 0x8000_0004 -> rvalid one cycle after each handshake, rdata 0x00000013 then 0x00100093, rresp 00.
- N=0, arvalid+rready with araddr 0x8000_0004 -> arready=1, rvalid=1, rdata 0x00100093 same cycle, state stays IDLE; repeat with rready=0 for 3 cycles -> rvalid held, rdata stable, arready=0 until consumed.
- araddr 0x8000_0002 and 0x8000_4000 (DEPTH=4096) -> rresp 2'b10, rdata 0.
- N=3, RAND_DELAY=1, 200 reads -> every delay within 3..6, all four values observed, data correct.
- Assert rst while in WAIT (N=5, 2 cycles in) -> rvalid=0 immediately, arready=1 after release, subsequent read returns correct data.
- ld_we to word 7 with value 0xDEAD_BEEF in same cycle as N=0 read of 0x8000_001C -> returns old value; next read returns 0xDEADBEEF.
